// File: rtl/input_debouncer_if.sv
// Raw button/switch levels in, debounced levels and press/change pulses out.
// master drives the raw inputs; slave is the debouncer.
interface input_debouncer_if #(
  parameter int NB_BTN = 4,
  parameter int NB_SW  = 4
);
  logic [NB_BTN-1:0] i_btn;
  logic [NB_SW-1:0]  i_sw;
  logic [NB_BTN-1:0] o_btn;
  logic [NB_BTN-1:0] o_btn_press;
  logic [NB_SW-1:0]  o_sw;
  logic              o_sw_chg;

  modport master (
    output i_btn, i_sw,
    input  o_btn, o_btn_press, o_sw, o_sw_chg
  );

  modport slave (
    input  i_btn, i_sw,
    output o_btn, o_btn_press, o_sw, o_sw_chg
  );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stability counter per raw input; a change is accepted
// after DEB_LIMIT consecutive cycles at the new level, latency 2+DEB_LIMIT edges.
module input_debouncer_chan #(
  parameter int                NB_DEB    = 20,
  parameter logic [NB_DEB-1:0] LIMIT_M1  = '1,
  parameter bit                RISE_ONLY = 1'b0
) (
  input  logic clock,
  input  logic ck_rst,
  input  logic raw,
  output logic level,
  output logic evt
);
  logic              sync1;
  logic              sync2;
  logic              state;
  logic [NB_DEB-1:0] cnt;
  logic              accept;

  assign accept = (sync2 != state) && (cnt == LIMIT_M1);
  // Buttons only report the accepted 0->1; switches report every accepted change.
  assign evt    = RISE_ONLY ? (accept & sync2) : accept;
  assign level  = state;

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == state) begin
        cnt <= '0;
      end else if (accept) begin
        state <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + NB_DEB'(1);
      end
    end
  end
endmodule

module input_debouncer #(
  parameter int     NB_BTN    = 4,
  parameter int     NB_SW     = 4,
  parameter int     NB_DEB    = 20,
  parameter longint DEB_LIMIT = 2**20
) (
  input  logic                clock,
  input  logic                ck_rst,
  input_debouncer_if.slave    dbus
);
  localparam int NB_CH = NB_BTN + NB_SW;
  // Computed in 64 bits then truncated so DEB_LIMIT == 2**NB_DEB yields all-ones.
  localparam logic [NB_DEB-1:0] LIMIT_M1 = NB_DEB'(DEB_LIMIT - 64'sd1);

  logic [NB_CH-1:0]  raw;
  logic [NB_CH-1:0]  level;
  logic [NB_CH-1:0]  evt;
  logic [NB_BTN-1:0] btn_press;
  logic              sw_chg;

  assign raw = {dbus.i_sw, dbus.i_btn};

  for (genvar k = 0; k < NB_CH; k++) begin : g_ch
    input_debouncer_chan #(
      .NB_DEB    (NB_DEB),
      .LIMIT_M1  (LIMIT_M1),
      .RISE_ONLY (k < NB_BTN)
    ) u_chan (
      .clock (clock),
      .ck_rst(ck_rst),
      .raw   (raw[k]),
      .level (level[k]),
      .evt   (evt[k])
    );
  end

  // Pulses register on the same edge as the level, so they align with its first new cycle.
  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      btn_press <= '0;
      sw_chg    <= 1'b0;
    end else begin
      btn_press <= evt[NB_BTN-1:0];
      sw_chg    <= |evt[NB_CH-1:NB_BTN];
    end
  end

  assign dbus.o_btn       = level[NB_BTN-1:0];
  assign dbus.o_sw        = level[NB_CH-1:NB_BTN];
  assign dbus.o_btn_press = btn_press;
  assign dbus.o_sw_chg    = sw_chg;
endmodule
